// File: rtl/perf_counter_reader.sv
// Performance event counter bank with a valid/ready read/write port; PERF_SNAPSHOT_EN adds a snap input and shadow bank.
// Latency: response registered one cycle after request accept; single-entry output buffer.
// Backpressure: req_ready drops while a response is held and resp_ready is low.
module perf_counter_reader #(
    parameter int NUM_EVENT = 16,
    parameter int INC_W     = 3,
    parameter int CNT_W     = 64,
    parameter int IDX_W     = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_EVENT*INC_W-1:0] event_inc,
`ifdef PERF_SNAPSHOT_EN
    input  logic                       snap,
`endif
    input  logic                       freeze,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic [IDX_W-1:0]           req_idx,
    input  logic [CNT_W-1:0]           req_wdata,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [CNT_W-1:0]           resp_data,
    output logic                       resp_ovf,
    output logic                       resp_err
);

    logic [CNT_W-1:0]     cnt_q [NUM_EVENT];
    logic [CNT_W-1:0]     cnt_d [NUM_EVENT];
    logic [NUM_EVENT-1:0] ovf_q;
    logic [NUM_EVENT-1:0] ovf_d;
    logic [CNT_W:0]       sum   [NUM_EVENT];
    logic [NUM_EVENT-1:0] wr_sel;

    logic                 accept;
    logic                 idx_ok;
    logic [CNT_W-1:0]     rd_cnt;
    logic                 rd_ovf;

    logic                 resp_vld_q, resp_vld_d;
    logic [CNT_W-1:0]     resp_dat_q, resp_dat_d;
    logic                 resp_ovf_q, resp_ovf_d;
    logic                 resp_err_q, resp_err_d;

    assign req_ready  = !resp_vld_q || resp_ready;
    assign accept     = req_valid && req_ready;
    // Extra bit so the compare stays correct when NUM_EVENT == 2**IDX_W.
    assign idx_ok     = ({1'b0, req_idx} < (IDX_W+1)'(NUM_EVENT));

    assign resp_valid = resp_vld_q;
    assign resp_data  = resp_dat_q;
    assign resp_ovf   = resp_ovf_q;
    assign resp_err   = resp_err_q;

    for (genvar g = 0; g < NUM_EVENT; g++) begin : g_evt
        assign sum[g]    = {1'b0, cnt_q[g]}
                         + {{(CNT_W+1-INC_W){1'b0}}, event_inc[g*INC_W +: INC_W]};
        assign wr_sel[g] = accept && req_we && idx_ok && (req_idx == IDX_W'(g));
    end

    // A write to a counter overrides that counter's increment in the same cycle.
    always_comb begin
        for (int i = 0; i < NUM_EVENT; i++) begin
            cnt_d[i] = cnt_q[i];
            ovf_d[i] = ovf_q[i];
            if (wr_sel[i]) begin
                cnt_d[i] = req_wdata;
                ovf_d[i] = 1'b0;
            end else if (!freeze) begin
                cnt_d[i] = sum[i][CNT_W-1:0];
                if (sum[i][CNT_W]) begin
                    ovf_d[i] = 1'b1;
                end
            end
        end
    end

`ifdef PERF_SNAPSHOT_EN
    logic [CNT_W-1:0]     snap_cnt_q [NUM_EVENT];
    logic [CNT_W-1:0]     snap_cnt_d [NUM_EVENT];
    logic [NUM_EVENT-1:0] snap_ovf_q;
    logic [NUM_EVENT-1:0] snap_ovf_d;

    // Snapshot captures end-of-cycle live values, so it includes this cycle's increments.
    always_comb begin
        for (int i = 0; i < NUM_EVENT; i++) begin
            snap_cnt_d[i] = snap_cnt_q[i];
            snap_ovf_d[i] = snap_ovf_q[i];
            if (snap) begin
                snap_cnt_d[i] = cnt_d[i];
                snap_ovf_d[i] = ovf_d[i];
            end else if (wr_sel[i]) begin
                snap_cnt_d[i] = req_wdata;
                snap_ovf_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_EVENT; i++) begin
                snap_cnt_q[i] <= '0;
            end
            snap_ovf_q <= '0;
        end else begin
            for (int i = 0; i < NUM_EVENT; i++) begin
                snap_cnt_q[i] <= snap_cnt_d[i];
            end
            snap_ovf_q <= snap_ovf_d;
        end
    end
`endif

    always_comb begin
        rd_cnt = '0;
        rd_ovf = 1'b0;
        for (int i = 0; i < NUM_EVENT; i++) begin
            if (req_idx == IDX_W'(i)) begin
`ifdef PERF_SNAPSHOT_EN
                rd_cnt = snap_cnt_q[i];
                rd_ovf = snap_ovf_q[i];
`else
                rd_cnt = cnt_q[i];
                rd_ovf = ovf_q[i];
`endif
            end
        end
    end

    always_comb begin
        resp_vld_d = resp_vld_q;
        resp_dat_d = resp_dat_q;
        resp_ovf_d = resp_ovf_q;
        resp_err_d = resp_err_q;
        if (accept) begin
            resp_vld_d = 1'b1;
            resp_dat_d = (!req_we && idx_ok) ? rd_cnt : '0;
            resp_ovf_d = !req_we && idx_ok && rd_ovf;
            resp_err_d = !idx_ok;
        end else if (resp_ready) begin
            resp_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_EVENT; i++) begin
                cnt_q[i] <= '0;
            end
            ovf_q      <= '0;
            resp_vld_q <= 1'b0;
            resp_dat_q <= '0;
            resp_ovf_q <= 1'b0;
            resp_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_EVENT; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            ovf_q      <= ovf_d;
            resp_vld_q <= resp_vld_d;
            resp_dat_q <= resp_dat_d;
            resp_ovf_q <= resp_ovf_d;
            resp_err_q <= resp_err_d;
        end
    end

endmodule

// File: tb/tb_perf_counter_reader.sv
// Directed bench for perf_counter_reader: counting, wrap/overflow, write priority, freeze, backpressure, range errors, reset.
module tb_perf_counter_reader;

    localparam int NE = 16;
    localparam int IW = 3;
    localparam int CW = 64;
    localparam int XW = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [NE*IW-1:0] event_inc;
    logic            freeze;
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [XW-1:0]   req_idx;
    logic [CW-1:0]   req_wdata;
    logic            resp_valid;
    logic            resp_ready;
    logic [CW-1:0]   resp_data;
    logic            resp_ovf;
    logic            resp_err;
`ifdef PERF_SNAPSHOT_EN
    logic            snap;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    perf_counter_reader #(
        .NUM_EVENT(NE), .INC_W(IW), .CNT_W(CW), .IDX_W(XW)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .event_inc  (event_inc),
`ifdef PERF_SNAPSHOT_EN
        .snap       (snap),
`endif
        .freeze     (freeze),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_idx    (req_idx),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_ovf   (resp_ovf),
        .resp_err   (resp_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NE*IW-1:0] inc1(input int idx, input int v);
        logic [NE*IW-1:0] r;
        r = '0;
        r[idx*IW +: IW] = IW'(v);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Refresh the shadow bank so reads observe live counts when snapshots are built in.
    task automatic snap_sync();
`ifdef PERF_SNAPSHOT_EN
        snap = 1'b1;
        tick();
        snap = 1'b0;
`endif
    endtask

    task automatic xact(input logic we, input int idx, input logic [63:0] wd,
                        input logic [NE*IW-1:0] inc,
                        output logic [63:0] rd, output logic ro, output logic re);
        int n;
        n         = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_idx   = XW'(idx);
        req_wdata = wd;
        event_inc = inc;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("req_rdy_timeout", 64'd0, 64'd1);
        tick();
        req_valid = 1'b0;
        event_inc = '0;
        chk("resp_valid_lat", {63'd0, resp_valid}, 64'd1);
        rd = resp_data;
        ro = resp_ovf;
        re = resp_err;
    endtask

    task automatic rd_chk(input string tag, input int idx, input logic [63:0] ed, input logic eo);
        logic [63:0] d;
        logic        o, e;
        snap_sync();
        xact(1'b0, idx, 64'd0, '0, d, o, e);
        chk({tag, "_data"}, d, ed);
        chk({tag, "_ovf"}, {63'd0, o}, {63'd0, eo});
        chk({tag, "_err"}, {63'd0, e}, 64'd0);
    endtask

    task automatic wr_chk(input string tag, input int idx, input logic [63:0] wd, input logic [NE*IW-1:0] inc);
        logic [63:0] d;
        logic        o, e;
        xact(1'b1, idx, wd, inc, d, o, e);
        chk({tag, "_data"}, d, 64'd0);
        chk({tag, "_ovf"}, {63'd0, o}, 64'd0);
        chk({tag, "_err"}, {63'd0, e}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef PERF_SNAPSHOT_EN
        logic [63:0] sd;
        logic        so, se;
        snap = 1'b0;
`endif
        rst        = 1'b0;
        event_inc  = '0;
        freeze     = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_idx    = '0;
        req_wdata  = '0;
        resp_ready = 1'b1;
        #23;
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_resp_data", resp_data, 64'd0);
        chk("rst_resp_ovf", {63'd0, resp_ovf}, 64'd0);
        chk("rst_resp_err", {63'd0, resp_err}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);

        // 10 cycles of +3 on event 0
        event_inc = inc1(0, 3);
        repeat (10) tick();
        event_inc = '0;
        rd_chk("cnt30", 0, 64'd30, 1'b0);

        // wrap-around sets sticky overflow, cleared by write
        wr_chk("wr_near_max", 2, 64'hFFFF_FFFF_FFFF_FFFE, '0);
        event_inc = inc1(2, 5);
        tick();
        event_inc = '0;
        rd_chk("wrap", 2, 64'd3, 1'b1);
        wr_chk("wr_clr", 2, 64'd0, '0);
        rd_chk("cleared", 2, 64'd0, 1'b0);

        // write beats same-cycle increment
        wr_chk("wr_prio", 1, 64'd100, inc1(1, 7));
        rd_chk("prio", 1, 64'd100, 1'b0);

        // freeze
        freeze    = 1'b1;
        event_inc = inc1(3, 2);
        repeat (20) tick();
        event_inc = '0;
        rd_chk("frozen", 3, 64'd0, 1'b0);
        wr_chk("wr_frozen", 4, 64'd55, '0);
        rd_chk("frozen_wr", 4, 64'd55, 1'b0);
        freeze    = 1'b0;
        event_inc = inc1(3, 2);
        repeat (4) tick();
        event_inc = '0;
        rd_chk("unfrozen", 3, 64'd8, 1'b0);

        // backpressure, then consume and accept an out-of-range read in the same cycle
        snap_sync();
        tick();
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_idx    = XW'(0);
        tick();
        chk("bp_valid", {63'd0, resp_valid}, 64'd1);
        chk("bp_data0", resp_data, 64'd30);
        chk("bp_rdy0", {63'd0, req_ready}, 64'd0);
        req_idx   = XW'(20);
        event_inc = inc1(0, 1);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_hold_rdy", {63'd0, req_ready}, 64'd0);
            chk("bp_hold_data", resp_data, 64'd30);
        end
        event_inc  = '0;
        resp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("oor_valid", {63'd0, resp_valid}, 64'd1);
        chk("oor_err", {63'd0, resp_err}, 64'd1);
        chk("oor_data", resp_data, 64'd0);
        chk("oor_ovf", {63'd0, resp_ovf}, 64'd0);
        tick();
        chk("drained", {63'd0, resp_valid}, 64'd0);
        rd_chk("after_bp", 0, 64'd35, 1'b0);

        // reset with a response pending
        tick();
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_idx    = XW'(1);
        tick();
        req_valid = 1'b0;
        chk("pend_valid", {63'd0, resp_valid}, 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_mid_valid", {63'd0, resp_valid}, 64'd0);
        @(negedge clk);
        rst        = 1'b1;
        resp_ready = 1'b1;
        tick();
        rd_chk("rst_lost", 1, 64'd0, 1'b0);

`ifdef PERF_SNAPSHOT_EN
        wr_chk("snap_wr0", 0, 64'd0, '0);
        event_inc = inc1(0, 1);
        repeat (49) tick();
        snap = 1'b1;
        tick();
        snap = 1'b0;
        repeat (10) tick();
        event_inc = '0;
        xact(1'b0, 0, 64'd0, '0, sd, so, se);
        chk("snap50", sd, 64'd50);
        tick();
        snap = 1'b1;
        tick();
        snap = 1'b0;
        xact(1'b0, 0, 64'd0, '0, sd, so, se);
        chk("snap60", sd, 64'd60);
`endif

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/perf_counter_reader.md
Name: perf_counter_reader

Overview:
- Collects per-cycle performance event increments from pipeline stages and keeps them in a bank of wide counters.
- Serves them to a software or debug reader through a valid/ready request/response port.
- Sits beside the core as the read-out end of the performance-event path. Stages only assert event increments; this block counts, freezes, clears and returns the counters on demand.
- Response is registered with a single-entry output buffer.

Parameters:
- NUM_EVENT, 16, number of counters/events
- INC_W, 3, width of per-event increment per cycle (multi-issue events, max 7/cycle)
- CNT_W, 64, counter width
- IDX_W, 5, width of reader index (must satisfy 2^IDX_W >= NUM_EVENT)

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-low
- event_inc  in  NUM_EVENT*INC_W  per-event increment this cycle; slice i = bits [i*INC_W +: INC_W]
- freeze  in  1  level; while 1, no counter advances
- req_valid  in  1  read/write request valid
- req_ready  out  1  request accepted when req_valid & req_ready
- req_we  in  1  1 = write counter, 0 = read
- req_idx  in  IDX_W  counter index
- req_wdata  in  CNT_W  write value
- resp_valid  out  1  response valid
- resp_ready  in  1  response consumed when resp_valid & resp_ready
- resp_data  out  CNT_W  counter value (read) or 0 (write)
- resp_ovf  out  1  sticky overflow flag of the addressed counter
- resp_err  out  1  req_idx >= NUM_EVENT

Behaviour:
- Reset (rst low, async): all counters 0, all ovf flags 0, resp_valid 0, resp_data 0, resp_ovf 0, resp_err 0. req_ready 1 after reset release.
- Counting: each cycle, for every i with freeze=0: cnt[i] <= cnt[i] + event_inc[i], zero-extended to CNT_W.
- Wrap-around: arithmetic is modulo 2^CNT_W. A carry out of bit CNT_W-1 sets ovf[i], which stays set until written.
- req_ready = !resp_valid | resp_ready. The response buffer is 1 entry, so back-to-back requests get full throughput when resp_ready is held 1.
- Read accepted in cycle N: resp_valid=1 in cycle N+1. resp_data = cnt[idx] value before cycle N's increment, resp_ovf = ovf[idx] before cycle N's update, resp_err=0.
- Write accepted in cycle N:
  - cnt[idx] <= req_wdata and ovf[idx] <= 0 at end of cycle N.
  - Write wins over the same-cycle increment to that counter; that increment is dropped.
  - Response in N+1 with resp_data=0, resp_ovf=0, resp_err=0.
- Out-of-range idx (>= NUM_EVENT): no state change. Response in N+1 with resp_data=0, resp_ovf=0, resp_err=1.
- Response holds stable while resp_valid & !resp_ready.
- Simultaneous consume and accept in the same cycle: the new response loads and resp_valid stays 1.
- freeze affects counting only. Reads and writes proceed while frozen; a write while frozen takes effect.
- Reset mid-transaction: pending response is discarded (resp_valid 0) and all counts are lost.

Optional Feature:
- Macro: PERF_SNAPSHOT_EN. Adds input port snap (1 bit) and a shadow bank snap_cnt[NUM_EVENT], snap_ovf[NUM_EVENT], reset to 0.
- On a snap pulse in cycle N, the shadow bank captures the live counters as updated at end of cycle N, including cycle N's increments.
- Reads return the shadow bank; live counting continues. Writes update both the live and shadow entries.
- Without the macro: no snap port, no shadow storage, reads return live counters.

Test Plan:
- Reset, then event_inc[0]=3 for 10 cycles, then read idx 0 -> resp_valid one cycle after accept, resp_data=30, resp_ovf=0, resp_err=0.
- Write idx 2 = 2^64-2, then event_inc[2]=5 for 1 cycle, then read idx 2 -> resp_data=3, resp_ovf=1. Write idx 2 = 0, then read -> resp_data=0, resp_ovf=0.
- Write idx 1 = 100 in the same cycle as event_inc[1]=7 -> later read gives 100 (increment dropped).
- freeze=1 with event_inc[3]=2 for 20 cycles -> read returns unchanged value. freeze=0 for 4 cycles -> +8.
- resp_ready=0 for 5 cycles after a read -> req_ready=0, resp_data stable. A read of idx 20 with NUM_EVENT=16 -> resp_err=1, resp_data=0.
- With PERF_SNAPSHOT_EN: count event 0 to 50, snap, count 10 more cycles at +1 -> read gives 50. Snap again -> read gives 60.
